// File: rtl/column_pattern_gen.sv
// column_pattern_gen: produces one wall column per request. The column has a
// gap of gw rows whose position comes from a 16-bit LFSR and stays within
// MAX_STEP rows of the previous gap. After 8 rejected draws the previous gap
// is kept, clamped so that it still fits inside the column.
module column_pattern_gen #(
  parameter  int ROWS     = 8,
  parameter  int MAX_STEP = 2,
  localparam int CW       = $clog2(ROWS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req,
  input  logic            seed_load,
  input  logic [15:0]     seed,
  input  logic [CW-1:0]   gap_w,
  output logic            valid,
  output logic            busy,
  output logic [ROWS-1:0] column,
  output logic [CW-1:0]   gap_pos
);

  typedef enum logic [1:0] {S_IDLE, S_DRAW, S_EMIT} state_t;

  localparam logic [CW:0]   L_ROWS  = (CW+1)'(ROWS);
  localparam logic [31:0]   L_STEP  = 32'(MAX_STEP);
  localparam logic [CW-1:0] L_GP_RST = CW'(ROWS/2 - 1);

  state_t          r_state;
  logic [15:0]     r_lfsr;
  logic [2:0]      r_retry;
  logic [CW-1:0]   r_gw;
  logic            r_valid;
  logic [ROWS-1:0] r_column;
  logic [CW-1:0]   r_gap_pos;

  logic [CW-1:0]   w_gw_clamp;
  logic [CW-1:0]   w_cand;
  logic [CW:0]     w_lim;
  logic [CW-1:0]   w_diff;
  logic            w_accept;
  logic            w_give_up;
  logic [CW-1:0]   w_fallback;
  logic [CW-1:0]   w_gp_next;
  logic [ROWS-1:0] w_gap_ones;
  logic [ROWS-1:0] w_col_next;
  logic [15:0]     w_lfsr_step;
  logic [15:0]     w_seed;

  // gap_w can never exceed ROWS-1 at this width, so only zero needs clamping
  assign w_gw_clamp  = (gap_w == '0) ? CW'(1) : gap_w;
  assign w_cand      = r_lfsr[CW-1:0];
  assign w_lim       = L_ROWS - {1'b0, r_gw};
  assign w_diff      = (w_cand >= r_gap_pos) ? (w_cand - r_gap_pos) : (r_gap_pos - w_cand);
  assign w_accept    = ({1'b0, w_cand} <= w_lim) && (32'(w_diff) <= L_STEP);
  assign w_give_up   = (r_retry == 3'd7);
  // lim < gap_pos < ROWS on the clamp path, so lim fits in CW bits there
  assign w_fallback  = ({1'b0, r_gap_pos} <= w_lim) ? r_gap_pos : w_lim[CW-1:0];
  assign w_gp_next   = w_accept ? w_cand : w_fallback;
  // gw ones at the bottom, moved up to the gap position, then inverted
  assign w_gap_ones  = {ROWS{1'b1}} >> w_lim;
  assign w_col_next  = ~(w_gap_ones << w_gp_next);
  assign w_lfsr_step = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  // an all-zero seed would lock the LFSR up
  assign w_seed      = (seed == 16'h0000) ? 16'h0001 : seed;

  assign valid   = r_valid;
  assign busy    = (r_state != S_IDLE);
  assign column  = r_column;
  assign gap_pos = r_gap_pos;

  // FSM, LFSR and registered column outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_lfsr    <= 16'hACE1;
      r_retry   <= 3'd0;
      r_gw      <= CW'(1);
      r_valid   <= 1'b0;
      r_column  <= '0;
      r_gap_pos <= L_GP_RST;
    end else begin
      r_valid <= 1'b0;
      if (seed_load)
        r_lfsr <= w_seed;
      else if (r_state == S_DRAW)
        r_lfsr <= w_lfsr_step;
      case (r_state)
        S_IDLE: begin
          if (req) begin
            r_state <= S_DRAW;
            r_gw    <= w_gw_clamp;
            r_retry <= 3'd0;
          end
        end
        S_DRAW: begin
          if (w_accept || w_give_up) begin
            r_state   <= S_EMIT;
            r_gap_pos <= w_gp_next;
            r_column  <= w_col_next;
            r_valid   <= 1'b1;
          end else begin
            r_retry <= r_retry + 3'd1;
          end
        end
        S_EMIT:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_column_pattern_gen.sv
// Bench for column_pattern_gen: two instances (MAX_STEP=2 and MAX_STEP=0)
// share all inputs. A transaction-level model works out each column when the
// request is taken and is compared against both instances on every cycle.
// Directed cases carry hand-computed literal expectations.
module tb_column_pattern_gen;

  localparam int ROWS = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req = 1'b0;
  logic            seed_load = 1'b0;
  logic [15:0]     seed = 16'h0;
  logic [2:0]      gap_w = 3'd0;
  logic [1:0]      valid_w, busy_w;
  logic [1:0][7:0] col_w;
  logic [1:0][2:0] gp_w;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  column_pattern_gen #(.ROWS(ROWS), .MAX_STEP(2)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed(seed),
    .gap_w(gap_w), .valid(valid_w[0]), .busy(busy_w[0]), .column(col_w[0]),
    .gap_pos(gp_w[0]));

  column_pattern_gen #(.ROWS(ROWS), .MAX_STEP(0)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .seed_load(seed_load), .seed(seed),
    .gap_w(gap_w), .valid(valid_w[1]), .busy(busy_w[1]), .column(col_w[1]),
    .gap_pos(gp_w[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [7:0] colf(input int gp, input int gw);
    logic [7:0] r;
    for (int i = 0; i < ROWS; i++) r[i] = !(i >= gp && i < gp + gw);
    return r;
  endfunction

  // Runs the whole draw up front: number of draw cycles, resulting gap, LFSR
  function automatic void draw(input logic [15:0] l0, input int gp0, input int gw,
                               input int ms, output int n, output int gp1,
                               output logic [15:0] l1);
    logic [15:0] l;
    logic [2:0]  lo;
    int c, d;
    l = l0;
    for (int k = 0; k < 8; k++) begin
      lo = l[2:0];
      c = int'(lo);
      l = step(l);
      d = (c > gp0) ? c - gp0 : gp0 - c;
      if (c <= ROWS - gw && d <= ms) begin
        n = k + 1; gp1 = c; l1 = l;
        return;
      end
    end
    n = 8;
    gp1 = (gp0 < ROWS - gw) ? gp0 : ROWS - gw;
    l1 = l;
  endfunction

  int          ms_of[2] = '{2, 0};
  logic [15:0] m_lfsr[2];
  int          m_gp[2];
  logic [7:0]  m_col[2];
  bit          m_valid[2];
  int          m_wait[2];
  logic [15:0] p_lfsr[2];
  int          p_gp[2];
  logic [7:0]  p_col[2];
  bit          started = 0;
  int          cyc = 0;
  int          last_v[2] = '{-100, -100};
  int          pulses = 0;

  // Advance the model at each edge, then compare every output a moment later
  always @(posedge clk) begin
    bit idle;
    int gw, n;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_lfsr[i] = 16'hACE1; m_gp[i] = 3; m_col[i] = 8'h00;
        m_valid[i] = 0; m_wait[i] = 0; last_v[i] = -100;
        started = 1;
      end else if (started) begin
        idle = (m_wait[i] == 0) && !m_valid[i];
        m_valid[i] = 0;
        if (seed_load) m_lfsr[i] = (seed == 16'h0) ? 16'h0001 : seed;
        if (m_wait[i] > 0) begin
          m_wait[i]--;
          if (m_wait[i] == 0) begin
            m_valid[i] = 1; m_gp[i] = p_gp[i]; m_col[i] = p_col[i]; m_lfsr[i] = p_lfsr[i];
          end
        end else if (idle && req) begin
          gw = (gap_w == 3'd0) ? 1 : int'(gap_w);
          draw(m_lfsr[i], m_gp[i], gw, ms_of[i], n, p_gp[i], p_lfsr[i]);
          p_col[i] = colf(p_gp[i], gw);
          m_wait[i] = n;
        end
      end
    end
    cyc++;
    #1;
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("valid%0d", i), 32'(valid_w[i]), 32'(m_valid[i]));
        chk($sformatf("busy%0d", i), 32'(busy_w[i]), 32'((m_wait[i] > 0) || m_valid[i]));
        chk($sformatf("column%0d", i), 32'(col_w[i]), 32'(m_col[i]));
        chk($sformatf("gap_pos%0d", i), 32'(gp_w[i]), 32'(m_gp[i]));
        if (valid_w[i]) begin
          if (i == 0) pulses++;
          if (last_v[i] >= 0) chk($sformatf("spacing%0d", i), 32'(cyc - last_v[i] >= 3), 32'd1);
          last_v[i] = cyc;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; req = 1'b0; seed_load = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    // reset state
    chk("rst_valid", 32'(valid_w[0]), 32'd0);
    chk("rst_busy", 32'(busy_w[0]), 32'd0);
    chk("rst_column", 32'(col_w[0]), 32'h00);
    chk("rst_gap_pos", 32'(gp_w[0]), 32'd3);

    // seed 5, gap 3: first candidate 5 accepted
    do_reset();
    seed_load = 1'b1; seed = 16'h0005; gap_w = 3'd3;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    chk("s5_t1_valid", 32'(valid_w[0]), 32'd0);
    chk("s5_t1_busy", 32'(busy_w[0]), 32'd1);
    tick();
    chk("s5_valid", 32'(valid_w[0]), 32'd1);
    chk("s5_gap_pos", 32'(gp_w[0]), 32'd5);
    chk("s5_column", 32'(col_w[0]), 32'h1F);
    tick();
    chk("s5_after_valid", 32'(valid_w[0]), 32'd0);
    chk("s5_after_busy", 32'(busy_w[0]), 32'd0);
    chk("s5_hold_column", 32'(col_w[0]), 32'h1F);

    // zero seed loads 1: candidate 1
    do_reset();
    seed_load = 1'b1; seed = 16'h0000; gap_w = 3'd3;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    chk("s0_valid", 32'(valid_w[0]), 32'd1);
    chk("s0_gap_pos", 32'(gp_w[0]), 32'd1);
    chk("s0_column", 32'(col_w[0]), 32'hF1);

    // MAX_STEP=0, gap 7: eight rejects then clamp to 1
    do_reset();
    gap_w = 3'd7; req = 1'b1;
    tick();
    req = 1'b0;
    repeat (7) tick();
    chk("ms0_t8_valid", 32'(valid_w[1]), 32'd0);
    chk("ms0_t8_busy", 32'(busy_w[1]), 32'd1);
    tick();
    chk("ms0_valid", 32'(valid_w[1]), 32'd1);
    chk("ms0_gap_pos", 32'(gp_w[1]), 32'd1);
    chk("ms0_column", 32'(col_w[1]), 32'h01);
    tick();
    chk("ms0_after_valid", 32'(valid_w[1]), 32'd0);

    // reset in the cycle after req aborts the draw
    do_reset();
    seed_load = 1'b1; seed = 16'h0005; gap_w = 3'd3;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_valid", 32'(valid_w[0]), 32'd0);
    chk("abort_busy", 32'(busy_w[0]), 32'd0);
    chk("abort_column", 32'(col_w[0]), 32'h00);
    chk("abort_gap_pos", 32'(gp_w[0]), 32'd3);
    repeat (4) tick();
    chk("abort_still_idle", 32'(busy_w[0]), 32'd0);

    // reset beats seed_load and req in the same cycle: LFSR stays ACE1
    reset = 1'b1; seed_load = 1'b1; seed = 16'h0005; req = 1'b1; gap_w = 3'd3;
    tick();
    reset = 1'b0; seed_load = 1'b0;
    chk("rprio_busy", 32'(busy_w[0]), 32'd0);
    tick();
    req = 1'b0;
    tick();
    chk("rprio_valid", 32'(valid_w[0]), 32'd1);
    chk("rprio_gap_pos", 32'(gp_w[0]), 32'd1);
    chk("rprio_column", 32'(col_w[0]), 32'hF1);
    tick();

    // req held high with random gap widths
    pulses = 0;
    req = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      gap_w = 3'($urandom_range(0, 7));
      tick();
    end
    req = 1'b0;
    repeat (12) tick();
    chk("stream_pulses_seen", 32'(pulses > 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
